// File: rtl/shift_word_ctrl.sv
// ============================================================================
// Module   : shift_word_ctrl
// Purpose  : Serial-to-word capture controller. Shifts bits into a WIDTH-bit
//            register after an explicit start, locks each completed word into
//            a held output register and hands it to a consumer over a
//            valid/ready handshake. Aborts a partial word after TIMEOUT
//            consecutive idle cycles.
// Options  : SHIFT_WORD_CTRL_CONT_EN - continuous capture mode (no HOLD,
//            keeps shifting after each word, sticky overrun on dropped words).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_word_ctrl #(
  parameter int WIDTH   = 4,   // bits per word (2..16)
  parameter int TIMEOUT = 15   // idle cycles tolerated mid-word (1..255)
) (
  input  logic             Aclk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             lock,
  output logic             timeout,
  output logic             overrun
);

  localparam int c_CNT_W  = $clog2(WIDTH) + 1;
  localparam int c_IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0]  c_LAST_BIT = c_CNT_W'(WIDTH - 1);
  localparam logic [c_IDLE_W-1:0] c_TMO      = c_IDLE_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [c_IDLE_W-1:0]  idle_q, idle_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [WIDTH-1:0]     word_q, word_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 lock_q, lock_d;
  logic                 tmo_q, tmo_d;
  logic                 ovr_q, ovr_d;

  logic [WIDTH-1:0]     w_shifted;
  logic [c_IDLE_W-1:0]  w_idle_inc;

  // Shift-in value and saturating idle count used by the next-state logic
  assign w_shifted  = {shreg_q[WIDTH-2:0], bit_in};
  assign w_idle_inc = (idle_q == c_TMO) ? idle_q : idle_q + 1'b1;

  // Next-state and output decode for the capture FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    valid_d = valid_q;
    lock_d  = 1'b0;
    tmo_d   = 1'b0;
    ovr_d   = ovr_q;

    // Consumer handshake retires the held word regardless of capture state;
    // a completion on the same edge below re-asserts valid.
    if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          idle_d  = '0;
          shreg_d = '0;
        end
      end

      S_SHIFT: begin
        if (bit_valid) begin
          shreg_d = w_shifted;
          idle_d  = '0;
          if (cnt_q == c_LAST_BIT) begin
            cnt_d = '0;
`ifdef SHIFT_WORD_CTRL_CONT_EN
            // Keep streaming; a word finishing against an unconsumed one is lost
            state_d = S_SHIFT;
            if (valid_q && !word_ready) begin
              ovr_d = 1'b1;
            end else begin
              word_d  = w_shifted;
              valid_d = 1'b1;
              lock_d  = 1'b1;
            end
`else
            state_d = S_HOLD;
            word_d  = w_shifted;
            valid_d = 1'b1;
            lock_d  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          idle_d = w_idle_inc;
          if (w_idle_inc == c_TMO) begin
            // Abort: partial word discarded, held output untouched
            state_d = S_IDLE;
            tmo_d   = 1'b1;
            cnt_d   = '0;
            shreg_d = '0;
          end
        end
      end

      S_HOLD: begin
        if (valid_q && word_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge Aclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      lock_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      lock_q  <= lock_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign busy       = busy_q;
  assign lock       = lock_q;
  assign timeout    = tmo_q;
`ifdef SHIFT_WORD_CTRL_CONT_EN
  assign overrun    = ovr_q;
`else
  assign overrun    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_word_ctrl.sv
// ============================================================================
// Module   : tb_shift_word_ctrl
// Purpose  : Self-checking bench for shift_word_ctrl. Directed scenarios plus
//            randomized traffic compared against a behavioural model that
//            tracks collected bits in a queue.
// Options  : SHIFT_WORD_CTRL_CONT_EN - also exercises continuous mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_word_ctrl;

  localparam int W  = 4;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         bit_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         word_ready = 1'b0;
  logic [W-1:0] word_out;
  logic         word_valid, busy, lock, timeout, overrun;

  int n_assert = 0;
  int n_fail   = 0;

  shift_word_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .Aclk       (clk),
    .reset      (reset),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .lock       (lock),
    .timeout    (timeout),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Behavioural model: capturing / holding flags, queue of collected bits
  bit           m_capturing, m_holding;
  bit           m_bits[$];
  int           m_idle;
  logic [W-1:0] m_word;
  bit           m_valid, m_lock, m_to, m_ovr;

  task automatic model_reset();
    m_capturing = 0; m_holding = 0; m_bits.delete(); m_idle = 0;
    m_word = '0; m_valid = 0; m_lock = 0; m_to = 0; m_ovr = 0;
  endtask

  task automatic model_edge(input bit st, input bit bi, input bit bv, input bit rdy);
    bit           valid_before;
    logic [W-1:0] w;
    valid_before = m_valid;
    m_lock = 0;
    m_to   = 0;
    if (valid_before && rdy) m_valid = 0;
    if (m_holding) begin
      if (valid_before && rdy) m_holding = 0;
    end else if (!m_capturing) begin
      if (st) begin
        m_capturing = 1; m_bits.delete(); m_idle = 0;
      end
    end else if (bv) begin
      m_bits.push_back(bi);
      m_idle = 0;
      if (m_bits.size() == W) begin
        w = '0;
        foreach (m_bits[i]) w = {w[W-2:0], m_bits[i]};
        m_bits.delete();
`ifdef SHIFT_WORD_CTRL_CONT_EN
        if (valid_before && !rdy) m_ovr = 1;
        else begin m_word = w; m_valid = 1; m_lock = 1; end
`else
        m_word = w; m_valid = 1; m_lock = 1;
        m_capturing = 0; m_holding = 1;
`endif
      end
    end else begin
      m_idle++;
      if (m_idle >= TO) begin
        m_capturing = 0; m_to = 1; m_bits.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".word_out"},   32'(word_out),   32'(m_word));
    chk({tag, ".word_valid"}, 32'(word_valid), 32'(m_valid));
    chk({tag, ".busy"},       32'(busy),       32'(m_capturing || m_holding));
    chk({tag, ".lock"},       32'(lock),       32'(m_lock));
    chk({tag, ".timeout"},    32'(timeout),    32'(m_to));
    chk({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check after
  task automatic step(input string tag, input bit st, input bit bi, input bit bv, input bit rdy);
    start = st; bit_in = bi; bit_valid = bv; word_ready = rdy;
    @(posedge clk);
    model_edge(st, bi, bv, rdy);
    #1;
    check_all(tag);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge
  task automatic async_reset(input string tag);
    start = 0; bit_valid = 0; word_ready = 0;
    #2;
    reset = 1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic send_word(input string tag, input logic [W-1:0] w, input bit rdy);
    logic [W-1:0] v;
    v = w;
    for (int i = W - 1; i >= 0; i--) step(tag, 0, v[i], 1, rdy);
  endtask

  initial begin
    int dens;
    model_reset();
    async_reset("reset");

    // Word 1011 with ready high
    step("t1_start", 1, 1, 1, 1);
    send_word("t1_bits", 4'b1011, 1);
    chk("t1_word_const", 32'(word_out), 32'hB);
    chk("t1_lock_const", 32'(lock), 32'h1);
    step("t1_accept", 0, 0, 0, 1);
    chk("t1_busy_after", 32'(busy), 32'h0);
    step("t1_idle", 0, 0, 0, 1);

    // Word 0110 held under backpressure with stray bits and starts
    step("t2_start", 1, 0, 0, 0);
    send_word("t2_bits", 4'b0110, 0);
    for (int i = 0; i < 10; i++) step("t2_hold", 1'($urandom), 1'($urandom), 1'($urandom), 0);
    chk("t2_word_held", 32'(word_out), 32'h6);
    chk("t2_busy_held", 32'(busy), 32'h1);
    step("t2_accept", 0, 0, 0, 1);
    chk("t2_valid_fall", 32'(word_valid), 32'h0);

    // Timeout after two bits and fifteen idle cycles
    step("t3_start", 1, 0, 0, 0);
    step("t3_b0", 0, 1, 1, 0);
    step("t3_b1", 0, 0, 1, 0);
    for (int i = 0; i < TO; i++) step("t3_idle", 0, 0, 0, 0);
    chk("t3_timeout_const", 32'(timeout), 32'h1);
    chk("t3_busy_const", 32'(busy), 32'h0);
    step("t3_after", 0, 0, 0, 0);
    // Bit arriving on the fifteenth idle cycle wins
    step("t3b_start", 1, 0, 0, 0);
    step("t3b_b0", 0, 1, 1, 0);
    step("t3b_b1", 0, 1, 1, 0);
    for (int i = 0; i < TO - 1; i++) step("t3b_idle", 0, 0, 0, 0);
    step("t3b_late_bit", 0, 0, 1, 0);
    chk("t3b_no_timeout", 32'(timeout), 32'h0);
    chk("t3b_still_busy", 32'(busy), 32'h1);
    step("t3b_last", 0, 1, 1, 0);
    chk("t3b_word_const", 32'(word_out), 32'hD);
    step("t3b_accept", 0, 0, 0, 1);

    // Reset mid-SHIFT and in HOLD, then a clean capture
    step("t4_start", 1, 0, 0, 0);
    step("t4_b0", 0, 1, 1, 0);
    step("t4_b1", 0, 1, 1, 0);
    async_reset("t4_rst_shift");
    step("t4_start2", 1, 0, 0, 0);
    send_word("t4_bits", 4'b1111, 0);
    async_reset("t4_rst_hold");
    step("t4_start3", 1, 0, 0, 0);
    send_word("t4_clean", 4'b1001, 0);
    chk("t4_clean_word", 32'(word_out), 32'h9);
    step("t4_accept", 0, 0, 0, 1);

`ifdef SHIFT_WORD_CTRL_CONT_EN
    // Second word dropped under backpressure
    async_reset("c1_rst");
    step("c1_start", 1, 0, 0, 0);
    send_word("c1_w0", 4'b1010, 0);
    send_word("c1_w1", 4'b1100, 0);
    chk("c1_overrun", 32'(overrun), 32'h1);
    chk("c1_word_kept", 32'(word_out), 32'hA);
    // Handshake on the completion edge loads the new word
    async_reset("c2_rst");
    step("c2_start", 1, 0, 0, 0);
    send_word("c2_w0", 4'b1010, 0);
    step("c2_b0", 0, 1, 1, 0);
    step("c2_b1", 0, 1, 1, 0);
    step("c2_b2", 0, 0, 1, 0);
    step("c2_b3", 0, 0, 1, 1);
    chk("c2_word_new", 32'(word_out), 32'hC);
    chk("c2_valid", 32'(word_valid), 32'h1);
    chk("c2_no_overrun", 32'(overrun), 32'h0);
`endif

    // Randomized traffic in blocks of varying bit density
    async_reset("rnd_rst");
    for (int blk = 0; blk < 20; blk++) begin
      dens = (blk % 5 == 4) ? 0 : int'($urandom_range(30, 100));
      for (int i = 0; i < 30; i++) begin
        step("rnd",
             ($urandom_range(0, 3) == 0),
             1'($urandom),
             (int'($urandom_range(1, 100)) <= dens),
             ($urandom_range(0, 2) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
